// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Signal bundle between the MEM pipeline stage, the data bus
//               and the write-back / hazard logic for mem_access_ctrl.
//               modport master : the controller (issues bus requests)
//               modport slave  : the surrounding pipeline / bus environment
// Ports       : mem_valid_i, mem_opcode_i, mem_addr_i, mem_wdata_i  (MEM stage)
//               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
//               bus_ack_i, bus_rdata_i                              (data bus)
//               rdata_o, wb_done_o, err_o, busy_o                   (status)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  logic        mem_valid_i;
  logic [5:0]  mem_opcode_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [31:0] rdata_o;
  logic        wb_done_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    input  mem_valid_i, mem_opcode_i, mem_addr_i, mem_wdata_i,
    input  bus_ack_i, bus_rdata_i,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output rdata_o, wb_done_o, err_o, busy_o
  );

  modport slave (
    output mem_valid_i, mem_opcode_i, mem_addr_i, mem_wdata_i,
    output bus_ack_i, bus_rdata_i,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  rdata_o, wb_done_o, err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage data-bus access controller. Accepts LW/SW in IDLE,
//               issues a registered bus request, waits for bus_ack_i with a
//               bounded timeout, and reports a one-cycle completion pulse
//               with error flag and load data for write-back.
// Ports       : clk  - single rising-edge clock
//               rst  - asynchronous active-low reset
//               mif  - mem_access_ctrl_if.master (MEM stage, bus, status)
// Parameters  : TIMEOUT_CYCLES - max REQ cycles without ack (1..1023)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_access_ctrl_if.master   mif
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  // Counter value seen during the last permitted REQ cycle.
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [9:0]  tmo_cnt;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nxt;
  logic        we_q, err_q, err_nxt;
  logic        accept, misaligned, tmo_hit;

  // ---------------------------------------------------------------------------
  // Next-state and completion values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    err_nxt    = 1'b0;
    rdata_nxt  = rdata_q;
    accept     = 1'b0;
    misaligned = (mif.mem_addr_i[1:0] != 2'b00);
    tmo_hit    = 1'b0;

    case (state)
      IDLE: begin
        accept = mif.mem_valid_i &&
                 ((mif.mem_opcode_i == OP_LW) || (mif.mem_opcode_i == OP_SW));
        if (accept) begin
          if (misaligned) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // Ack wins over timeout, including in the final permitted cycle.
        if (mif.bus_ack_i) begin
          state_nxt = DONE;
          rdata_nxt = we_q ? 32'd0 : mif.bus_rdata_i;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
          err_nxt   = 1'b1;
          rdata_nxt = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= mif.mem_addr_i;
        wdata_q <= mif.mem_wdata_i;
        we_q    <= (mif.mem_opcode_i == OP_SW);
      end
      if (accept) begin
        tmo_cnt <= '0;
      end else if ((state == REQ) && !mif.bus_ack_i && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 10'd1;
      end
      // err_nxt is only nonzero on the transition into DONE, so err_q is
      // high exactly during the DONE cycle of a failed access.
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from registers)
  // ---------------------------------------------------------------------------
  assign mif.bus_req_o   = (state == REQ);
  assign mif.bus_we_o    = we_q;
  assign mif.bus_addr_o  = addr_q;
  assign mif.bus_wdata_o = wdata_q;
  assign mif.rdata_o     = rdata_q;
  assign mif.wb_done_o   = (state == DONE);
  assign mif.err_o       = err_q;
  assign mif.busy_o      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Each access outcome
//               (request length, completion latency, error, load data) is
//               predicted from the access rules and compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;
  localparam int T = 4;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if mif ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_rdata = 32'd0;

  // One access. ack_at = REQ cycle index carrying the ack (0 = never;
  // values beyond T land after the request window and must be ignored).
  task automatic do_access(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rd, input bit noise,
                           input string name);
    int exp_req, exp_done, req_cycles, done_c;
    logic exp_err, err_seen, is_store;
    logic [31:0] rdata_seen;
    bit field_bad;
    req_cycles = 0; done_c = 0; err_seen = 1'b0; rdata_seen = '0; field_bad = 0;
    is_store = (op == SW);
    if (addr[1:0] != 2'b00) begin
      exp_req = 0; exp_done = 1; exp_err = 1'b1; exp_rdata = 32'd0;
    end else if (ack_at >= 1 && ack_at <= T) begin
      exp_req = ack_at; exp_done = ack_at + 1; exp_err = 1'b0;
      exp_rdata = is_store ? 32'd0 : rd;
    end else begin
      exp_req = T; exp_done = T + 1; exp_err = 1'b1; exp_rdata = 32'd0;
    end

    @(negedge clk);
    mif.mem_valid_i = 1'b1; mif.mem_opcode_i = op;
    mif.mem_addr_i = addr;  mif.mem_wdata_i = wdata;
    mif.bus_ack_i = 1'b0;
    for (int c = 1; c <= T + 4 && done_c == 0; c++) begin
      @(negedge clk);
      if (mif.bus_req_o === 1'b1) begin
        req_cycles++;
        if (mif.bus_addr_o !== addr || mif.bus_we_o !== is_store ||
            mif.bus_wdata_o !== wdata) field_bad = 1;
      end
      if (mif.wb_done_o === 1'b1) begin
        done_c = c; err_seen = mif.err_o; rdata_seen = mif.rdata_o;
      end
      if (noise && done_c == 0) begin
        mif.mem_valid_i = 1'b1; mif.mem_opcode_i = LW;
        mif.mem_addr_i = $urandom & 32'hFFFF_FFFC; mif.mem_wdata_i = $urandom;
      end else begin
        mif.mem_valid_i = 1'b0;
      end
      mif.bus_ack_i   = (c == ack_at);
      mif.bus_rdata_i = (c == ack_at) ? rd : $urandom;
    end

    vectors++;
    if (done_c === 0) begin
      miscompares++;
      $display("FAIL %s done_timeout: no wb_done_o within %0d cycles", name, T + 4);
    end
    vectors++;
    if (done_c !== exp_done) begin
      miscompares++;
      $display("FAIL %s done_latency: got %0d want %0d", name, done_c, exp_done);
    end
    vectors++;
    if (req_cycles !== exp_req) begin
      miscompares++;
      $display("FAIL %s req_cycles: got %0d want %0d", name, req_cycles, exp_req);
    end
    vectors++;
    if (err_seen !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %b want %b", name, err_seen, exp_err);
    end
    vectors++;
    if (rdata_seen !== exp_rdata) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", name, rdata_seen, exp_rdata);
    end
    vectors++;
    if (field_bad) begin
      miscompares++;
      $display("FAIL %s bus_fields: addr/we/wdata differ from %h/%b/%h",
               name, addr, is_store, wdata);
    end

    // Following cycle must be IDLE with rdata held; any pending ack is stray.
    @(negedge clk);
    mif.bus_ack_i = 1'b0;
    vectors++;
    if (mif.busy_o !== 1'b0 || mif.wb_done_o !== 1'b0 || mif.bus_req_o !== 1'b0 ||
        mif.rdata_o !== exp_rdata) begin
      miscompares++;
      $display("FAIL %s post_idle: busy=%b done=%b req=%b rdata=%h want 0/0/0/%h",
               name, mif.busy_o, mif.wb_done_o, mif.bus_req_o, mif.rdata_o, exp_rdata);
    end
  endtask

  task automatic test_reset();
    mif.mem_valid_i = 1'b0; mif.mem_opcode_i = '0; mif.mem_addr_i = '0;
    mif.mem_wdata_i = '0; mif.bus_ack_i = 1'b0; mif.bus_rdata_i = '0;
    rst = 1'b0;
    exp_rdata = 32'd0;
    #12;
    vectors++;
    if ({mif.bus_req_o, mif.bus_we_o, mif.wb_done_o, mif.err_o, mif.busy_o} !== 5'b0 ||
        mif.bus_addr_o !== 32'd0 || mif.bus_wdata_o !== 32'd0 || mif.rdata_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b we=%b done=%b err=%b busy=%b addr=%h wd=%h rd=%h want all 0",
               mif.bus_req_o, mif.bus_we_o, mif.wb_done_o, mif.err_o, mif.busy_o,
               mif.bus_addr_o, mif.bus_wdata_o, mif.rdata_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    do_access(LW, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0, "lw_ack2");
    do_access(SW, 32'h204, 32'h12345678, 1, 32'hCAFEF00D, 0, "sw_ack1");
    do_access(LW, 32'h102, 32'h0, 1, 32'h11111111, 0, "lw_misaligned");
    do_access(LW, 32'h300, 32'h0, 0, 32'h0, 0, "lw_timeout");
    do_access(LW, 32'h304, 32'h0, T, 32'hA5A5A5A5, 0, "lw_ack_last");
    do_access(LW, 32'h308, 32'h0, T + 1, 32'h5A5A5A5A, 0, "lw_ack_late");
  endtask

  task automatic test_ignore_during_busy();
    do_access(LW, 32'h400, 32'h0, 2, 32'h0BADF00D, 1, "lw_second_req");
  endtask

  task automatic test_stray_and_illegal();
    logic [5:0] op;
    bit bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mif.busy_o !== 1'b0 || mif.bus_req_o !== 1'b0 || mif.wb_done_o !== 1'b0) bad = 1;
      do op = 6'($urandom); while (op == LW || op == SW);
      mif.mem_valid_i = (i % 2 == 0) ? 1'b1 : 1'b0;
      mif.mem_opcode_i = (i % 2 == 0) ? op : LW;  // odd cycles: LW but not valid
      mif.mem_addr_i = $urandom & 32'hFFFF_FFFC;
      mif.bus_ack_i = 1'b1;
      mif.bus_rdata_i = $urandom;
    end
    @(negedge clk);
    if (mif.busy_o !== 1'b0 || mif.bus_req_o !== 1'b0 || mif.wb_done_o !== 1'b0 ||
        mif.rdata_o !== exp_rdata) bad = 1;
    mif.mem_valid_i = 1'b0; mif.bus_ack_i = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL idle_ignore: busy=%b req=%b done=%b rdata=%h want 0/0/0/%h",
               mif.busy_o, mif.bus_req_o, mif.wb_done_o, mif.rdata_o, exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    done_seen = 0;
    @(negedge clk);
    mif.mem_valid_i = 1'b1; mif.mem_opcode_i = LW; mif.mem_addr_i = 32'h40;
    mif.bus_ack_i = 1'b0;
    @(negedge clk);
    mif.mem_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (mif.bus_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_req_before: got %b want 1", mif.bus_req_o);
    end
    rst = 1'b0;
    exp_rdata = 32'd0;
    #1;
    vectors++;
    if (mif.bus_req_o !== 1'b0 || mif.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: req=%b busy=%b want 0/0", mif.bus_req_o, mif.busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mif.wb_done_o !== 1'b0) done_seen = 1;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mif.wb_done_o !== 1'b0) done_seen = 1;
    end
    vectors++;
    if (done_seen) begin
      miscompares++;
      $display("FAIL midrst_no_done: got wb_done_o pulse want none");
    end
    do_access(LW, 32'h80, 32'h0, 1, 32'h76543210, 0, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? LW : SW;
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      do_access(op, addr, $urandom, $urandom_range(0, T + 2), $urandom,
                bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_during_busy();
    test_stray_and_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
